// File: rtl/multi_channel_controller.sv
// Byte-stream command parser driving NUM_CH staged actuator set-points (shadow + output).
// Optional watchdog enabled by defining CTRL_WATCHDOG_EN.
module multi_channel_controller #(
    parameter int unsigned      NUM_CH   = 4,
    parameter int unsigned      VAL_W    = 7,
    parameter int unsigned      TIMEOUT  = 4000000,
    parameter logic [VAL_W-1:0] SAFE_VAL = '0
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    data_ready,
    input  logic [7:0]              data,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH*VAL_W-1:0] out,
    output logic                    busy,
    output logic                    cmd_err,
    output logic                    fault
);

    localparam bit TwoByte = (VAL_W > 7);

    typedef enum logic [1:0] {StIdle, StDataHi, StDataLo} state_e;

    state_e           state_q;
    logic [5:0]       ch_q;
    logic             commit_q;
    logic [VAL_W-1:0] shadow_q [NUM_CH];

    logic             is_hdr;
    logic             is_dat;
    logic             complete;
    logic             ch_valid;
    logic             fire;
    logic [VAL_W-1:0] cmd_val;

    assign is_hdr   = data_ready & data[7];
    assign is_dat   = data_ready & ~data[7];
    assign complete = (state_q == StDataLo) & is_dat;
    assign ch_valid = (32'(ch_q) < NUM_CH);
    assign busy     = (state_q != StIdle);

    if (TwoByte) begin : g_two_byte
        logic [VAL_W-8:0] hi_q;

        always_ff @(posedge clk) begin
            if (clr) begin
                hi_q <= '0;
            end else if ((state_q == StDataHi) && is_dat) begin
                hi_q <= data[VAL_W-8:0];
            end
        end

        assign cmd_val = {hi_q, data[6:0]};
    end else begin : g_one_byte
        assign cmd_val = data[VAL_W-1:0];
    end

`ifdef CTRL_WATCHDOG_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] wd_q;

    // A completion in the firing cycle takes precedence over the timeout.
    assign fire = ~complete & (wd_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clr || complete || fire) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            commit_q <= 1'b0;
            cmd_err  <= 1'b0;
            fault    <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                shadow_q[k]            <= SAFE_VAL;
                out[k*VAL_W +: VAL_W]  <= SAFE_VAL;
            end
        end else if (fire) begin
            state_q <= StIdle;
            cmd_err <= 1'b0;
            fault   <= 1'b1;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                shadow_q[k]            <= SAFE_VAL;
                out[k*VAL_W +: VAL_W]  <= SAFE_VAL;
            end
        end else begin
            fault   <= 1'b0;
            cmd_err <= (is_hdr & (state_q != StIdle)) |
                       (is_dat & (state_q == StIdle)) |
                       (complete & ~ch_valid);

            if (is_hdr) begin
                state_q  <= TwoByte ? StDataHi : StDataLo;
                ch_q     <= data[5:0];
                commit_q <= data[6];
            end else if (is_dat) begin
                case (state_q)
                    StDataHi: state_q <= StDataLo;
                    StDataLo: state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end

            // Later assignment wins, so a completing write bypasses a same-cycle load.
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (load[k]) begin
                    out[k*VAL_W +: VAL_W] <= shadow_q[k];
                end
                if (complete && ch_valid && (int'(ch_q) == k)) begin
                    shadow_q[k] <= cmd_val;
                    if (commit_q || load[k]) begin
                        out[k*VAL_W +: VAL_W] <= cmd_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_controller.sv
// Directed scoreboard bench for multi_channel_controller (7-bit and 10-bit instances).
module tb_multi_channel_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1;
    logic        data_ready = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [3:0]  load = 4'h0;
    logic [27:0] out;
    logic        busy, cmd_err, fault;

    logic        clr10 = 1'b1;
    logic        ready10 = 1'b0;
    logic [7:0]  data10 = 8'h00;
    logic [3:0]  load10 = 4'h0;
    logic [39:0] out10;
    logic        busy10, cmd_err10, fault10;

    multi_channel_controller #(
        .NUM_CH(4), .VAL_W(7), .TIMEOUT(100), .SAFE_VAL(7'd0)
    ) dut (
        .clk(clk), .clr(clr), .data_ready(data_ready), .data(data), .load(load),
        .out(out), .busy(busy), .cmd_err(cmd_err), .fault(fault)
    );

    multi_channel_controller #(
        .NUM_CH(4), .VAL_W(10), .TIMEOUT(100), .SAFE_VAL(10'd0)
    ) dut10 (
        .clk(clk), .clr(clr10), .data_ready(ready10), .data(data10), .load(load10),
        .out(out10), .busy(busy10), .cmd_err(cmd_err10), .fault(fault10)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h", obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic send(input logic [7:0] b);
        data_ready = 1'b1;
        data = b;
        tick();
        data_ready = 1'b0;
    endtask

    task automatic send10(input logic [7:0] b);
        ready10 = 1'b1;
        data10 = b;
        tick();
        ready10 = 1'b0;
    endtask

    function automatic logic [63:0] pack4(input logic [6:0] c3, input logic [6:0] c2,
                                          input logic [6:0] c1, input logic [6:0] c0);
        return {36'd0, c3, c2, c1, c0};
    endfunction

    logic seen_fault;

    initial begin
        tick();
        tick();
        clr = 1'b0;
        clr10 = 1'b0;

        push("reset_out", pack4(0, 0, 0, 0));          chk(out);
        push("reset_busy", 0);                         chk(busy);
        push("reset_cmd_err", 0);                      chk(cmd_err);
        push("reset_fault", 0);                        chk(fault);

        // 10-bit channel: two data bytes, then clr mid-command.
        push("w10_busy_hdr", 1);       send10(8'h80);  chk(busy10);
        push("w10_busy_hi", 1);        send10(8'h05);  chk(busy10);
        push("w10_busy_done", 0);      send10(8'h7F);  chk(busy10);
        load10 = 4'h1;
        push("w10_value", 10'h2FF);    tick();         chk(out10[9:0]);
        load10 = 4'h0;
        send10(8'h80);
        send10(8'h05);
        clr10 = 1'b1;
        push("w10_clr_busy", 0);       tick();         chk(busy10);
        clr10 = 1'b0;
        push("w10_stray_err", 1);      send10(8'h7F);  chk(cmd_err10);
        load10 = 4'h1;
        push("w10_clr_value", 0);      tick();         chk(out10[9:0]);
        load10 = 4'h0;

        // Staged write to channel 2, then load.
        push("hdr_busy", 1);           send(8'h82);    chk(busy);
        push("stage_no_commit", pack4(0, 0, 0, 0));
        send(8'h08);                                   chk(out);
        tick();
        load = 4'b0100;
        push("load_ch2", pack4(0, 8, 0, 0));
        tick();                                        chk(out);
        load = 4'h0;

        // Commit write to channel 1.
        send(8'hC1);
        push("commit_ch1", pack4(0, 8, 64, 0));
        send(8'h40);                                   chk(out);

        // Protocol errors.
        push("stray_data_err", 1);     send(8'h05);    chk(cmd_err);
        push("stray_data_busy", 0);                    chk(busy);
        push("err_one_cycle", 0);      tick();         chk(cmd_err);
        send(8'h80);
        push("abort_err", 1);          send(8'h81);    chk(cmd_err);
        push("abort_busy", 1);                         chk(busy);
        push("abort_done_err", 0);     send(8'h01);    chk(cmd_err);
        send(8'hC7);
        push("bad_ch_err", 1);         send(8'h11);    chk(cmd_err);
        push("bad_ch_out", pack4(0, 8, 64, 0));        chk(out);
        load = 4'hF;
        push("load_all", pack4(0, 8, 1, 0));
        tick();                                        chk(out);
        load = 4'h0;

        // Completion and load in the same cycle: channel 0 bypasses.
        send(8'h80);
        data_ready = 1'b1;
        data = 8'h2A;
        load = 4'hF;
        push("bypass", pack4(0, 8, 1, 7'h2A));
        tick();                                        chk(out);
        data_ready = 1'b0;
        load = 4'h0;

        for (int ch = 0; ch < 4; ch++) begin
            send(8'hC0 | 8'(ch));
            send(8'h33);
        end
        push("all_33", pack4(7'h33, 7'h33, 7'h33, 7'h33));
        chk(out);

`ifdef CTRL_WATCHDOG_EN
        seen_fault = 1'b0;
        repeat (99) begin
            tick();
            seen_fault = seen_fault | fault;
        end
        push("wd_no_early_fault", 0);                  chk(seen_fault);
        push("wd_fault", 1);           tick();         chk(fault);
        push("wd_safe_out", pack4(0, 0, 0, 0));        chk(out);
        push("wd_fault_pulse", 0);     tick();         chk(fault);
        repeat (97) tick();
        send(8'hC3);
        push("wd_race_out", pack4(7'h55, 0, 0, 0));
        send(8'h55);                                   chk(out);
        push("wd_race_fault", 0);                      chk(fault);
        push("wd_race_fault_next", 0); tick();         chk(fault);
`else
        seen_fault = 1'b0;
        repeat (150) begin
            tick();
            seen_fault = seen_fault | fault;
        end
        push("nowd_fault", 0);                         chk(seen_fault);
        push("nowd_out", pack4(7'h33, 7'h33, 7'h33, 7'h33));
        chk(out);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_controller.md
# multi_channel_controller

Parametrised command controller that turns a byte stream from the serial front end into `NUM_CH` staged actuator set-points (motors, servos). Each accepted command writes a per-channel shadow register. The shadow value reaches the actuator output on a per-channel load strobe, or immediately when the command requests it. A watchdog forces every channel to a safe value when commands stop arriving. The block sits between the byte receiver and the PWM generators.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels, range 1..64.
- `VAL_W`, default 7: set-point width, range 1..14.
- `TIMEOUT`, default 4000000: number of idle cycles before the watchdog fires; must be ≥ 2.
- `SAFE_VAL`, default 0: value `VAL_W` bits wide, forced on reset and on watchdog fault.

Ports:
- `clk`, in, 1: single clock; every register is clocked on its rising edge.
- `clr`, in, 1: synchronous, active-high reset; highest priority.
- `data_ready`, in, 1: `data` is valid this cycle; one byte is accepted per high cycle.
- `data`, in, 8: command byte.
- `load`, in, `NUM_CH`: per-channel copy from shadow to output; any combination of bits may be high.
- `out`, out, `NUM_CH*VAL_W`: channel k occupies `[k*VAL_W +: VAL_W]`.
- `busy`, out, 1: parser is in the middle of a command.
- `cmd_err`, out, 1: one-cycle pulse on a protocol error.
- `fault`, out, 1: one-cycle pulse when the watchdog fires.

## Operation
Byte format:
- Header byte: `data[7]=1`; `data[6]` = commit flag; `data[5:0]` = channel index.
- Data byte: `data[7]=0`; `data[6:0]` = 7-bit chunk.

Command length:
- `VAL_W ≤ 7`: header plus one data byte; value = `data[VAL_W-1:0]`.
- `VAL_W 8..14`: header plus two data bytes. The first carries value bits `[VAL_W-1:7]` in `data[VAL_W-8:0]`; the second carries bits `[6:0]`. Unused upper bits are ignored.

Parser FSM (states IDLE, DATA_HI, DATA_LO):
- IDLE + header → DATA_HI if `VAL_W > 7`, otherwise DATA_LO. Channel index and commit flag are latched.
- DATA_HI + data byte → DATA_LO; the high chunk is latched.
- DATA_LO + data byte → IDLE; the command is complete.
- A header in DATA_HI or DATA_LO aborts the current command, pulses `cmd_err`, and starts a new command.
- A data byte in IDLE is discarded and pulses `cmd_err`.
- Cycles with `data_ready=0` do not change state, and no timeout applies inside the parser.
- `busy` = 1 whenever the state is not IDLE.

Command completion:
- Valid channel index (< `NUM_CH`): the shadow register is written. If the commit flag is 1, `out` for that channel is written at the same edge.
- Channel index ≥ `NUM_CH`: the value is discarded and `cmd_err` pulses. The command still counts as completed for the watchdog.

Load:
- `load[k]=1` copies shadow k to out k. Channels whose load bit is 0 hold their output.
- Completion for channel k in the same cycle as `load[k]`: out k takes the new value (bypass).

Watchdog:
- Counter width is `$clog2(TIMEOUT)`.
- Cleared at every completed command; otherwise increments every cycle.
- In the cycle the counter equals `TIMEOUT-1` with no completion:
  - at the next edge every shadow and every output becomes `SAFE_VAL`;
  - the parser returns to IDLE;
  - the counter returns to 0;
  - `fault` is high for that one following cycle.
- A completion in the firing cycle wins: no fault.
- A pending `load` in the firing cycle is overridden by `SAFE_VAL`.

## Timing
- Reset values: `out` = `SAFE_VAL` on every channel, shadows = `SAFE_VAL`, state IDLE, counter 0, `busy`=0, `cmd_err`=0, `fault`=0.
- `clr` during a command drops the partial command.
- Shadow visible one cycle after the final data byte is sampled. With the commit flag, `out` changes in the same cycle as the shadow.
- `load` sampled at edge N → `out` changes after edge N (one cycle latency).
- `cmd_err` and `fault` are registered and assert the cycle after their cause.
- Command rate: up to one command every 2 cycles (`VAL_W ≤ 7`) or every 3 cycles (`VAL_W 8..14`); bytes may be back-to-back.

## Configuration
- `CTRL_WATCHDOG_EN` defined: watchdog is present, as described above.
- `CTRL_WATCHDOG_EN` not defined: no counter logic; `fault` is tied to 0; outputs change only by reset, load, or commit.

## Test plan
Bench parameters: `NUM_CH=4`, `VAL_W=7`, `TIMEOUT=100`, `SAFE_VAL=0`, `CTRL_WATCHDOG_EN` defined, unless stated otherwise.
- Header 0x82, then 0x08, then `load=4'b0100` two cycles later → channel 2 shadow = 8 after the data byte; `out[20:14]` = 8 one cycle after the load; other channels stay 0.
- Header 0xC1 (commit, channel 1), then 0x40 → `out[13:7]` = 64 one cycle after the data byte, with no load.
- Data byte 0x05 in IDLE → `cmd_err` pulse, no state change. Header 0x80 followed by header 0x81 → `cmd_err` pulse, `busy` stays 1. Header 0x87 plus data → `cmd_err` pulse, no channel written.
- Set every channel to 0x33, then 100 idle cycles → `fault` high for exactly one cycle, all `out` = 0. A command completing on cycle 99 instead → no fault.
- `load=4'b1111` in the same cycle that a commit-less command completes for channel 0 → channel 0 output gets the new value; channels 1..3 get their shadows.
- `VAL_W=10`, header 0x80, then 0x05, then 0x7F → channel 0 = 10'h2FF. `clr` asserted between the two data bytes → `busy`=0, channel 0 stays 0.
